// File: rtl/sram_arb_pkg.sv
// Shared defaults, FSM state type and index-width helper
// for the SRAM port arbiter.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = DEF_DATA_W / 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side bundle of the SRAM port arbiter:
// packed per-requester requests plus shared read return.
interface sram_port_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) ();
  localparam int BE_W = DATA_W / 8;

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ*BE_W-1:0]   be;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational rotating-priority picker: first set request
// at or after the start pointer, wrapping at N.
module rr_priority_picker
  import sram_arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, start} + (IW+1)'(k);
      if (pos >= (IW+1)'(N))
        pos = pos - (IW+1)'(N);
      if (!any && req[pos[IW-1:0]]) begin
        any                 = 1'b1;
        idx                 = pos[IW-1:0];
        onehot[pos[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin, burst-limited arbiter sharing one SRAM port
// among N requesters; read data is routed back by tag.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  sram_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_clken,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [DATA_W-1:0] sram_writedata,
  output logic [DATA_W/8-1:0] sram_byteenable,
  input  logic [DATA_W-1:0] sram_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IW    = idx_w(N_REQ);
  localparam int CW    = $clog2(MAX_BURST + 1);
  localparam int DEPTH = READ_LATENCY + 1;

  state_t        state;
  logic [IW-1:0] owner;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] cnt;

  logic [IW-1:0]    nxt_ptr;
  logic [IW-1:0]    start;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic             others;
  logic             keep;
  logic             accept;
  logic [IW-1:0]    acc_idx;
  logic             acc_we;
  logic [N_REQ-1:0] gnt;

  logic [DEPTH-1:0] rd_vld;
  logic [IW-1:0]    rd_tag [DEPTH];

  assign nxt_ptr = (owner == IW'(N_REQ - 1))
                 ? '0 : owner + IW'(1);

  // Leaving an owner re-arbitrates from the slot after it,
  // so the handover happens without a bubble.
  assign start = (state == ST_OWN) ? nxt_ptr : rr_ptr;

  rr_priority_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req    (bus.req),
    .start  (start),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    others  = |(bus.req & ~(N_REQ'(1) << owner));
    keep    = (state == ST_OWN) && bus.req[owner]
           && ((cnt < CW'(MAX_BURST)) || !others);
    gnt     = '0;
    acc_idx = owner;
    accept  = 1'b0;
    if (reset_n) begin
      if (keep) begin
        gnt[owner] = 1'b1;
        accept     = 1'b1;
      end else if (pick_any) begin
        gnt     = pick_oh;
        acc_idx = pick_idx;
        accept  = 1'b1;
      end
    end
    acc_we = bus.we[acc_idx];
  end

  assign bus.gnt    = gnt;
  assign bus.rvalid = rd_vld[DEPTH-1]
                    ? (N_REQ'(1) << rd_tag[DEPTH-1])
                    : '0;
  assign bus.rdata  = sram_readdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      owner           <= '0;
      rr_ptr          <= '0;
      cnt             <= '0;
      sram_clken      <= 1'b0;
      sram_chipselect <= 1'b0;
      sram_write      <= 1'b0;
      sram_address    <= '0;
      sram_writedata  <= '0;
      sram_byteenable <= '0;
      rd_vld          <= '0;
      for (int k = 0; k < DEPTH; k++)
        rd_tag[k] <= '0;
    end else begin
      sram_clken <= 1'b1;
      if ((state == ST_OWN) && !keep)
        rr_ptr <= nxt_ptr;
      if (keep) begin
        cnt <= (cnt == CW'(MAX_BURST))
             ? CW'(1) : cnt + CW'(1);
      end else if (accept) begin
        state <= ST_OWN;
        owner <= acc_idx;
        cnt   <= CW'(1);
      end else begin
        state <= ST_IDLE;
        cnt   <= '0;
      end
      sram_chipselect <= accept;
      if (accept) begin
        sram_address   <= bus.addr[acc_idx*ADDR_W +: ADDR_W];
        sram_write     <= acc_we;
        sram_writedata <= bus.wdata[acc_idx*DATA_W +: DATA_W];
        sram_byteenable <= acc_we
                         ? bus.be[acc_idx*BE_W +: BE_W]
                         : '1;
      end
      rd_vld    <= {rd_vld[DEPTH-2:0], accept && !acc_we};
      rd_tag[0] <= acc_idx;
      for (int k = 1; k < DEPTH; k++)
        rd_tag[k] <= rd_tag[k-1];
    end
  end

endmodule
